pmt_lookup_ctrl: RTL and testbench

Lookup sequencer that sits between the key extractor and the PMT pair (tcam_pmt plus action sram_pmt). It accepts one search key at a time through a valid/ready handshake and issues a TCAM search. On a hit it reads action data from the SRAM PMT at match_addr; on a miss it substitutes a programmable default action. It returns a tagged result through a valid/ready handshake and keeps hit, miss and error statistics.

---
 rtl/pmt_lookup_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_pmt_lookup_ctrl.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/pmt_lookup_ctrl.sv
// pmt_lookup_ctrl: TCAM search then action SRAM read per key, with default-action
// substitution on miss, read timeout detection and saturating statistics.
module pmt_lookup_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int TCAM_LAT = 1,
  parameter int RD_TIMEOUT = 15,
  parameter logic [DATA_WIDTH-1:0] DEFAULT_ACTION = '0,
  parameter int CNT_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  key_valid,
  output logic                  key_ready,
  input  logic [DATA_WIDTH-1:0] key_data,
  output logic                  tcam_search_en,
  output logic [DATA_WIDTH-1:0] tcam_search_key,
  input  logic                  tcam_match_found,
  input  logic [ADDR_WIDTH-1:0] tcam_match_addr,
  output logic                  sram_rd_en,
  output logic [ADDR_WIDTH-1:0] sram_rd_addr,
  input  logic [DATA_WIDTH-1:0] sram_rd_data,
  input  logic                  sram_rd_valid,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic                  res_hit,
  output logic                  res_err,
  output logic [ADDR_WIDTH-1:0] res_addr,
  output logic [DATA_WIDTH-1:0] res_key,
  output logic [DATA_WIDTH-1:0] res_action,
  input  logic                  cfg_def_we,
  input  logic [DATA_WIDTH-1:0] cfg_def_data,
  input  logic                  cnt_clr,
  output logic [CNT_WIDTH-1:0]  hit_cnt,
  output logic [CNT_WIDTH-1:0]  miss_cnt,
  output logic [CNT_WIDTH-1:0]  err_cnt
);
  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SEARCH = 3'd1;
  localparam logic [2:0] S_WAIT_M = 3'd2;
  localparam logic [2:0] S_READ   = 3'd3;
  localparam logic [2:0] S_WAIT_D = 3'd4;
  localparam logic [2:0] S_RESP   = 3'd5;
  localparam int LW = $clog2(TCAM_LAT + 1);
  localparam int TW = $clog2(RD_TIMEOUT + 1);

  logic [2:0]            state_q, state_d;
  logic                  key_ready_q, key_ready_d;
  logic                  srch_en_q, srch_en_d;
  logic [DATA_WIDTH-1:0] key_q, key_d;
  logic [LW-1:0]         lat_q, lat_d;
  logic                  rd_en_q, rd_en_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [TW-1:0]         to_q, to_d;
  logic                  res_valid_q, res_valid_d;
  logic                  res_hit_q, res_hit_d;
  logic                  res_err_q, res_err_d;
  logic [ADDR_WIDTH-1:0] res_addr_q, res_addr_d;
  logic [DATA_WIDTH-1:0] res_key_q, res_key_d;
  logic [DATA_WIDTH-1:0] res_action_q, res_action_d;
  logic [DATA_WIDTH-1:0] def_q, def_d;
  logic [CNT_WIDTH-1:0]  hit_q, hit_d, miss_q, miss_d, err_q, err_d;
  logic                  hit_inc, miss_inc, err_inc;

  always_comb begin
    state_d      = state_q;
    key_ready_d  = key_ready_q;
    srch_en_d    = 1'b0;
    key_d        = key_q;
    lat_d        = lat_q;
    rd_en_d      = 1'b0;
    addr_d       = addr_q;
    to_d         = to_q;
    res_valid_d  = res_valid_q;
    res_hit_d    = res_hit_q;
    res_err_d    = res_err_q;
    res_addr_d   = res_addr_q;
    res_key_d    = res_key_q;
    res_action_d = res_action_q;
    hit_inc      = 1'b0;
    miss_inc     = 1'b0;
    err_inc      = 1'b0;
    case (state_q)
      S_IDLE: if (key_valid) begin
        key_d       = key_data;
        key_ready_d = 1'b0;
        srch_en_d   = 1'b1;
        state_d     = S_SEARCH;
      end
      S_SEARCH: begin
        lat_d   = LW'(TCAM_LAT);
        state_d = S_WAIT_M;
      end
      S_WAIT_M: if (lat_q == LW'(1)) begin
        if (tcam_match_found) begin
          addr_d  = tcam_match_addr;
          rd_en_d = 1'b1;
          state_d = S_READ;
        end else begin
          res_action_d = def_q;
          res_hit_d    = 1'b0;
          res_err_d    = 1'b0;
          res_addr_d   = '0;
          res_key_d    = key_q;
          res_valid_d  = 1'b1;
          miss_inc     = 1'b1;
          state_d      = S_RESP;
        end
      end else lat_d = lat_q - LW'(1);
      S_READ: begin
        to_d    = '0;
        state_d = S_WAIT_D;
      end
      S_WAIT_D: if (sram_rd_valid || to_q == TW'(RD_TIMEOUT - 1)) begin
        res_action_d = sram_rd_valid ? sram_rd_data : def_q;
        res_hit_d    = 1'b1;
        res_err_d    = !sram_rd_valid;
        res_addr_d   = addr_q;
        res_key_d    = key_q;
        res_valid_d  = 1'b1;
        hit_inc      = sram_rd_valid;
        err_inc      = !sram_rd_valid;
        state_d      = S_RESP;
      end else to_d = to_q + TW'(1);
      S_RESP: if (res_ready) begin
        res_valid_d = 1'b0;
        key_ready_d = 1'b1;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // clear dominates a coincident increment; increments stop at all-ones
  assign hit_d  = cnt_clr ? '0 : (hit_inc && !(&hit_q)) ? hit_q + CNT_WIDTH'(1) : hit_q;
  assign miss_d = cnt_clr ? '0 : (miss_inc && !(&miss_q)) ? miss_q + CNT_WIDTH'(1) : miss_q;
  assign err_d  = cnt_clr ? '0 : (err_inc && !(&err_q)) ? err_q + CNT_WIDTH'(1) : err_q;
  assign def_d  = cfg_def_we ? cfg_def_data : def_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      key_ready_q  <= 1'b1;
      srch_en_q    <= 1'b0;
      key_q        <= '0;
      lat_q        <= '0;
      rd_en_q      <= 1'b0;
      addr_q       <= '0;
      to_q         <= '0;
      res_valid_q  <= 1'b0;
      res_hit_q    <= 1'b0;
      res_err_q    <= 1'b0;
      res_addr_q   <= '0;
      res_key_q    <= '0;
      res_action_q <= '0;
      def_q        <= DEFAULT_ACTION;
      hit_q        <= '0;
      miss_q       <= '0;
      err_q        <= '0;
    end else begin
      state_q      <= state_d;
      key_ready_q  <= key_ready_d;
      srch_en_q    <= srch_en_d;
      key_q        <= key_d;
      lat_q        <= lat_d;
      rd_en_q      <= rd_en_d;
      addr_q       <= addr_d;
      to_q         <= to_d;
      res_valid_q  <= res_valid_d;
      res_hit_q    <= res_hit_d;
      res_err_q    <= res_err_d;
      res_addr_q   <= res_addr_d;
      res_key_q    <= res_key_d;
      res_action_q <= res_action_d;
      def_q        <= def_d;
      hit_q        <= hit_d;
      miss_q       <= miss_d;
      err_q        <= err_d;
    end
  end

  assign key_ready       = key_ready_q;
  assign tcam_search_en  = srch_en_q;
  assign tcam_search_key = key_q;
  assign sram_rd_en      = rd_en_q;
  assign sram_rd_addr    = addr_q;
  assign res_valid       = res_valid_q;
  assign res_hit         = res_hit_q;
  assign res_err         = res_err_q;
  assign res_addr        = res_addr_q;
  assign res_key         = res_key_q;
  assign res_action      = res_action_q;
  assign hit_cnt         = hit_q;
  assign miss_cnt        = miss_q;
  assign err_cnt         = err_q;
endmodule

// File: tb/tb_pmt_lookup_ctrl.sv
// tb_pmt_lookup_ctrl: directed bench with behavioural TCAM (latency 1) and
// 1-cycle action SRAM models; 3-bit counters make saturation reachable.
module tb_pmt_lookup_ctrl;
  logic        clk, rst_n;
  logic        key_valid, key_ready;
  logic [31:0] key_data;
  logic        tcam_search_en;
  logic [31:0] tcam_search_key;
  logic        tcam_match_found;
  logic [4:0]  tcam_match_addr;
  logic        sram_rd_en;
  logic [4:0]  sram_rd_addr;
  logic [31:0] sram_rd_data;
  logic        sram_rd_valid;
  logic        res_valid, res_ready, res_hit, res_err;
  logic [4:0]  res_addr;
  logic [31:0] res_key, res_action;
  logic        cfg_def_we;
  logic [31:0] cfg_def_data;
  logic        cnt_clr;
  logic [2:0]  hit_cnt, miss_cnt, err_cnt;
  logic        sram_on, stray, mdl_valid;
  int          checks, errors;

  pmt_lookup_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .TCAM_LAT(1), .RD_TIMEOUT(15),
                    .DEFAULT_ACTION(32'h0), .CNT_WIDTH(3)) dut (
    .clk(clk), .rst_n(rst_n), .key_valid(key_valid), .key_ready(key_ready), .key_data(key_data),
    .tcam_search_en(tcam_search_en), .tcam_search_key(tcam_search_key),
    .tcam_match_found(tcam_match_found), .tcam_match_addr(tcam_match_addr),
    .sram_rd_en(sram_rd_en), .sram_rd_addr(sram_rd_addr), .sram_rd_data(sram_rd_data),
    .sram_rd_valid(sram_rd_valid), .res_valid(res_valid), .res_ready(res_ready),
    .res_hit(res_hit), .res_err(res_err), .res_addr(res_addr), .res_key(res_key),
    .res_action(res_action), .cfg_def_we(cfg_def_we), .cfg_def_data(cfg_def_data),
    .cnt_clr(cnt_clr), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt), .err_cnt(err_cnt));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // TCAM: entry 5 = C0A80001/FFFFFFFF, entry 9 = 0B000000/FF000000
  always @(posedge clk) if (tcam_search_en) begin
    tcam_match_found <= (tcam_search_key == 32'hC0A80001) || (tcam_search_key[31:24] == 8'h0B);
    tcam_match_addr  <= (tcam_search_key == 32'hC0A80001) ? 5'd5 : (tcam_search_key[31:24] == 8'h0B) ? 5'd9 : 5'd0;
  end

  always @(posedge clk) begin
    mdl_valid    <= sram_rd_en && sram_on;
    sram_rd_data <= (sram_rd_addr == 5'd5) ? 32'h0000AA55 : (sram_rd_addr == 5'd9) ? 32'h99990009 : 32'h0;
  end
  assign sram_rd_valid = mdl_valid || stray;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic lookup(input logic [31:0] k, output int n);
    key_valid = 1'b1;
    key_data = k;
    tick;
    key_valid = 1'b0;
    n = 0;
    while (!res_valid && n < 40) begin
      tick;
      n++;
    end
  endtask

  task automatic release_res;
    res_ready = 1'b1;
    tick;
    res_ready = 1'b0;
  endtask

  task automatic test_reset;
    checks++; if (key_ready !== 1'b1) begin errors++; $display("FAIL rst_key_ready got %b want 1", key_ready); end
    checks++; if ({res_valid, res_hit, res_err, tcam_search_en, sram_rd_en} !== 5'b0) begin errors++; $display("FAIL rst_strobes got %b want 00000", {res_valid, res_hit, res_err, tcam_search_en, sram_rd_en}); end
    checks++; if ({hit_cnt, miss_cnt, err_cnt} !== 9'b0) begin errors++; $display("FAIL rst_counters got %h want 000", {hit_cnt, miss_cnt, err_cnt}); end
  endtask

  task automatic test_hit;
    int n;
    key_valid = 1'b1;
    key_data = 32'hC0A80001;
    tick;
    key_valid = 1'b0;
    checks++; if ({key_ready, tcam_search_en, tcam_search_key} !== {2'b01, 32'hC0A80001}) begin errors++; $display("FAIL hit_search got %b %b %h want 0 1 c0a80001", key_ready, tcam_search_en, tcam_search_key); end
    n = 0;
    while (!res_valid && n < 40) begin tick; n++; end
    checks++; if (n != 4) begin errors++; $display("FAIL hit_latency got %0d want 4", n); end
    checks++; if ({res_hit, res_err, res_addr} !== {2'b10, 5'd5}) begin errors++; $display("FAIL hit_flags got %b %b %0d want 1 0 5", res_hit, res_err, res_addr); end
    checks++; if ({res_action, res_key} !== {32'h0000AA55, 32'hC0A80001}) begin errors++; $display("FAIL hit_data got %h %h want 0000aa55 c0a80001", res_action, res_key); end
    checks++; if (hit_cnt !== 3'd1) begin errors++; $display("FAIL hit_cnt got %0d want 1", hit_cnt); end
    release_res;
    checks++; if ({res_valid, key_ready} !== 2'b01) begin errors++; $display("FAIL hit_release got %b%b want 01", res_valid, key_ready); end
  endtask

  task automatic test_miss;
    int n;
    cfg_def_we = 1'b1;
    cfg_def_data = 32'hDEADBEEF;
    tick;
    cfg_def_we = 1'b0;
    lookup(32'h0A000003, n);
    checks++; if (n != 2) begin errors++; $display("FAIL miss_latency got %0d want 2", n); end
    checks++; if ({res_hit, res_err, res_addr} !== 7'b0) begin errors++; $display("FAIL miss_flags got %b %b %0d want 0 0 0", res_hit, res_err, res_addr); end
    checks++; if (res_action !== 32'hDEADBEEF) begin errors++; $display("FAIL miss_action got %h want deadbeef", res_action); end
    checks++; if ({miss_cnt, hit_cnt} !== {3'd1, 3'd1}) begin errors++; $display("FAIL miss_cnt got %0d/%0d want 1/1", miss_cnt, hit_cnt); end
    release_res;
  endtask

  task automatic test_timeout;
    int n;
    sram_on = 1'b0;
    lookup(32'h0B000001, n);
    checks++; if (n != 18) begin errors++; $display("FAIL to_latency got %0d want 18", n); end
    checks++; if ({res_hit, res_err, res_addr} !== {2'b11, 5'd9}) begin errors++; $display("FAIL to_flags got %b %b %0d want 1 1 9", res_hit, res_err, res_addr); end
    checks++; if (res_action !== 32'hDEADBEEF) begin errors++; $display("FAIL to_action got %h want deadbeef", res_action); end
    checks++; if ({err_cnt, hit_cnt} !== {3'd1, 3'd1}) begin errors++; $display("FAIL to_cnt got %0d/%0d want 1/1", err_cnt, hit_cnt); end
    release_res;
    sram_on = 1'b1;
  endtask

  task automatic test_back_to_back;
    int n;
    key_valid = 1'b1;
    key_data = 32'hC0A80001;
    tick;
    key_data = 32'h0A000003;
    n = 0;
    while (!res_valid && n < 40) begin tick; n++; end
    checks++; if (n != 4) begin errors++; $display("FAIL bp_latency got %0d want 4", n); end
    for (int i = 0; i < 10; i++) begin
      tick;
      checks++; if ({res_valid, key_ready, res_hit, res_err, res_addr, res_action, res_key} !== {4'b1010, 5'd5, 32'h0000AA55, 32'hC0A80001}) begin errors++; $display("FAIL bp_hold cycle %0d got %b%b%b%b %0d %h %h", i, res_valid, key_ready, res_hit, res_err, res_addr, res_action, res_key); end
    end
    res_ready = 1'b1;
    tick;
    res_ready = 1'b0;
    checks++; if ({res_valid, key_ready} !== 2'b01) begin errors++; $display("FAIL bp_release got %b%b want 01", res_valid, key_ready); end
    tick;
    key_valid = 1'b0;
    checks++; if ({key_ready, tcam_search_en, tcam_search_key} !== {2'b01, 32'h0A000003}) begin errors++; $display("FAIL bp_accept got %b %b %h want 0 1 0a000003", key_ready, tcam_search_en, tcam_search_key); end
    tick;
    cfg_def_we = 1'b1;
    cfg_def_data = 32'h11111111;
    tick;
    cfg_def_we = 1'b0;
    checks++; if ({res_valid, res_action} !== {1'b1, 32'hDEADBEEF}) begin errors++; $display("FAIL bp_def_race got %b %h want 1 deadbeef", res_valid, res_action); end
    checks++; if ({hit_cnt, miss_cnt} !== {3'd2, 3'd2}) begin errors++; $display("FAIL bp_cnt got %0d/%0d want 2/2", hit_cnt, miss_cnt); end
    release_res;
    lookup(32'h0A000004, n);
    checks++; if ({res_action, miss_cnt} !== {32'h11111111, 3'd3}) begin errors++; $display("FAIL def_new got %h %0d want 11111111 3", res_action, miss_cnt); end
    release_res;
  endtask

  task automatic test_reset_mid;
    sram_on = 1'b0;
    key_valid = 1'b1;
    key_data = 32'hC0A80001;
    tick;
    key_valid = 1'b0;
    repeat (5) tick;
    rst_n = 1'b0;
    #1;
    checks++; if ({key_ready, res_valid, res_hit, sram_rd_en, tcam_search_en} !== 5'b10000) begin errors++; $display("FAIL rmid_outputs got %b want 10000", {key_ready, res_valid, res_hit, sram_rd_en, tcam_search_en}); end
    checks++; if ({hit_cnt, miss_cnt, err_cnt} !== 9'b0) begin errors++; $display("FAIL rmid_counters got %h want 000", {hit_cnt, miss_cnt, err_cnt}); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    stray = 1'b1;
    tick;
    tick;
    stray = 1'b0;
    tick;
    checks++; if ({res_valid, key_ready, hit_cnt} !== {2'b01, 3'd0}) begin errors++; $display("FAIL rmid_late_valid got %b%b %0d want 01 0", res_valid, key_ready, hit_cnt); end
    sram_on = 1'b1;
  endtask

  task automatic test_cnt_clr;
    int n;
    for (int i = 0; i < 3; i++) begin lookup(32'hC0A80001, n); release_res; end
    checks++; if (hit_cnt !== 3'd3) begin errors++; $display("FAIL clr_pre got %0d want 3", hit_cnt); end
    key_valid = 1'b1;
    key_data = 32'hC0A80001;
    tick;
    key_valid = 1'b0;
    repeat (3) tick;
    cnt_clr = 1'b1;
    tick;
    cnt_clr = 1'b0;
    checks++; if ({res_valid, hit_cnt} !== {1'b1, 3'd0}) begin errors++; $display("FAIL clr_wins got %b %0d want 1 0", res_valid, hit_cnt); end
    release_res;
    for (int i = 0; i < 7; i++) begin lookup(32'hC0A80001, n); release_res; end
    checks++; if (hit_cnt !== 3'd7) begin errors++; $display("FAIL sat_reach got %0d want 7", hit_cnt); end
    lookup(32'hC0A80001, n);
    checks++; if ({n, hit_cnt} !== {32'd4, 3'd7}) begin errors++; $display("FAIL sat_hold got lat %0d cnt %0d want 4 7", n, hit_cnt); end
    checks++; if ({miss_cnt, err_cnt} !== 6'b0) begin errors++; $display("FAIL sat_others got %0d/%0d want 0/0", miss_cnt, err_cnt); end
    release_res;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b1;
    key_valid = 1'b0;
    key_data = '0;
    res_ready = 1'b0;
    cfg_def_we = 1'b0;
    cfg_def_data = '0;
    cnt_clr = 1'b0;
    sram_on = 1'b1;
    stray = 1'b0;
    tcam_match_found = 1'b0;
    tcam_match_addr = '0;
    #2 rst_n = 1'b0;
    tick;
    tick;
    test_reset;
    rst_n = 1'b1;
    tick;
    test_hit;
    test_miss;
    test_timeout;
    test_back_to_back;
    test_reset_mid;
    test_cnt_clr;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
